// File: rtl/fir_bist_if.sv
`default_nettype none
// ============================================================================
//  Module   : fir_bist_if
//  Purpose  : Bundles the BIST harness control, stimulus/response and result
//             signals into one port.
//  Signals  : start      run request (from controller)
//             mode       pattern select (from controller)
//             x_out      stimulus sample toward the FIR x input
//             y_in       FIR output sample back into the harness
//             busy/done  run status
//             signature  MISR result, valid while done
//             peak       largest unsigned y_in of the run, valid while done
//  Modports : slave  - the harness (fir_bist)
//             master - the surrounding pad mux / FIR core / test controller
//  Revision : 1.0  initial release
// ============================================================================
interface fir_bist_if #(
  parameter int BW_IN  = 6,
  parameter int BW_OUT = 8,
  parameter int SIG_W  = 16
);
  logic              start;
  logic [1:0]        mode;
  logic [BW_IN-1:0]  x_out;
  logic [BW_OUT-1:0] y_in;
  logic              busy;
  logic              done;
  logic [SIG_W-1:0]  signature;
  logic [BW_OUT-1:0] peak;

  modport slave (
    input  start, mode, y_in,
    output x_out, busy, done, signature, peak
  );

  modport master (
    output start, mode, y_in,
    input  x_out, busy, done, signature, peak
  );
endinterface
`default_nettype wire

// File: rtl/fir_bist.sv
`default_nettype none
// ============================================================================
//  Module   : fir_bist
//  Purpose  : On-chip stimulus/response harness for the FIR core. Flushes the
//             filter, drives one of four test patterns for N_SAMPLES cycles,
//             and compacts the latency-aligned response into a 16-bit MISR
//             signature plus the peak unsigned output value.
//  Ports    : clk   system clock, rising edge
//             rst   synchronous active-high reset
//             bus   fir_bist_if.slave (start, mode, y_in in;
//                   x_out, busy, done, signature, peak out)
//  Revision : 1.0  initial release
// ============================================================================
module fir_bist #(
  parameter int N_TAPS    = 5,
  parameter int BW_IN     = 6,
  parameter int BW_OUT    = 8,
  parameter int N_SAMPLES = 32,
  parameter int LAT       = 1,
  parameter int SIG_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  fir_bist_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0]        FLUSH_LAST = 8'(N_TAPS - 1);
  localparam logic [7:0]        RUN_LAST   = 8'(N_SAMPLES - 1);
  localparam logic [7:0]        DRAIN_LAST = 8'(LAT - 1);
  localparam logic [BW_IN-1:0]  PULSE      = {1'b0, {(BW_IN-1){1'b1}}};
  localparam logic [SIG_W-1:0]  MISR_POLY  = 16'h6801;
  localparam logic [SIG_W-1:0]  SIG_SEED   = {SIG_W{1'b1}};
  localparam logic [7:0]        LFSR_SEED  = 8'h01;

  state_t             state;
  state_t             state_next;
  logic               busy;
  logic               done;
  logic               start_ok;
  logic [7:0]         cnt;
  logic [7:0]         idx_next;
  logic [1:0]         mode_q;
  logic [7:0]         lfsr;
  logic [7:0]         lfsr_next;
  logic [BW_IN-1:0]   pat;
  logic [BW_IN-1:0]   x_reg;
  logic [SIG_W-1:0]   sig;
  logic [SIG_W-1:0]   misr_next;
  logic [BW_OUT-1:0]  peak;
  logic               capture;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and status outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    start_ok   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          start_ok   = 1'b1;
          state_next = S_FLUSH;
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (cnt == FLUSH_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        // With zero latency the last capture lands on the last RUN edge,
        // so there is nothing left to drain.
        if (cnt == RUN_LAST) state_next = (LAT == 0) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (cnt == DRAIN_LAST) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (bus.start) begin
          start_ok   = 1'b1;
          state_next = S_FLUSH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Per-state cycle counter; restarts at every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (state_next != state) begin
      cnt <= 8'd0;
    end else if (busy) begin
      cnt <= cnt + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus generation. x_out is registered, so the pattern is computed for
  // the sample index that the *next* cycle will hold.
  // --------------------------------------------------------------------------
  assign idx_next  = (state == S_RUN) ? (cnt + 8'd1) : 8'd0;
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_comb begin
    pat = '0;
    case (mode_q)
      2'd0:    pat = (idx_next == 8'd0) ? PULSE : '0;
      2'd1:    pat = PULSE;
      2'd2:    pat = lfsr[BW_IN-1:0];
      default: pat = idx_next[BW_IN-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg  <= '0;
      lfsr   <= LFSR_SEED;
      mode_q <= 2'd0;
    end else begin
      if (start_ok) begin
        mode_q <= bus.mode;
        lfsr   <= LFSR_SEED;
      end else if (state_next == S_RUN) begin
        lfsr <= lfsr_next;
      end
      if (state_next == S_RUN) begin
        x_reg <= pat;
      end else begin
        x_reg <= '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Capture alignment: a RUN-cycle marker delayed by the FIR latency.
  // --------------------------------------------------------------------------
  generate
    if (LAT == 0) begin : g_lat0
      assign capture = (state == S_RUN);
    end else begin : g_latn
      logic [LAT-1:0] vld;
      logic [LAT:0]   vld_shift;
      assign vld_shift = {vld, (state == S_RUN)};
      always_ff @(posedge clk) begin
        if (rst || start_ok) begin
          vld <= '0;
        end else begin
          vld <= vld_shift[LAT-1:0];
        end
      end
      assign capture = vld[LAT-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Response compaction: Galois MISR plus running unsigned maximum.
  // --------------------------------------------------------------------------
  assign misr_next = {sig[SIG_W-2:0], 1'b0}
                   ^ (sig[SIG_W-1] ? MISR_POLY : '0)
                   ^ SIG_W'(bus.y_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      sig  <= SIG_SEED;
      peak <= '0;
    end else if (start_ok) begin
      sig  <= SIG_SEED;
      peak <= '0;
    end else if (capture) begin
      sig <= misr_next;
      if (bus.y_in > peak) peak <= bus.y_in;
    end
  end

  assign bus.x_out     = x_reg;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.signature = sig;
  assign bus.peak      = peak;

endmodule
`default_nettype wire
